// File: rtl/i2c_target_rx_pkg.sv
// i2c_target_rx_pkg: state encodings and constants shared by the I2C target receiver.
package i2c_target_rx_pkg;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_ACK = 3'd4,
        S_IGNORE   = 3'd5
    } state_t;
    localparam logic [6:0] DEF_ADDR = 7'h42;
    localparam logic [3:0] BITS = 4'd8;
endpackage

// File: rtl/i2c_target_rx_if.sv
// i2c_target_rx_if: clock, ack control and received-byte signals of the I2C target receiver.
interface i2c_target_rx_if;
    import i2c_target_rx_pkg::*;
    logic sck;
    logic ack_en;
    logic [BITS-1:0] rx_data;
    logic rx_valid;
    logic rx_start;
    logic rx_stop;
    logic busy;
    modport slave (input sck, ack_en, output rx_data, rx_valid, rx_start, rx_stop, busy);
    modport master (output sck, ack_en, input rx_data, rx_valid, rx_start, rx_stop, busy);
endinterface

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: multi-flop synchroniser plus previous-sample flop giving level, rise and fall.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    // Reset to 1 so an idle bus produces no spurious edges when reset lifts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C write-only target; matches ADDR, ACKs it, and delivers data bytes with a valid pulse.
module i2c_target_rx
    import i2c_target_rx_pkg::*;
#(
    parameter logic [6:0] ADDR = DEF_ADDR,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic reset_n,
    i2c_target_rx_if.slave bus,
    inout wire sda
);
    state_t state, n_state;
    logic [3:0] cnt, n_cnt;
    logic [7:0] shift, n_shift, n_data;
    logic drive, n_drive, ack_q, n_ack_q, n_valid, n_start, n_stop;
    logic sck_l, sck_r, sck_f, sda_l, sda_r, sda_f, start_c, stop_c;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clk(clk), .reset_n(reset_n), .d(bus.sck), .level(sck_l), .rise(sck_r), .fall(sck_f)
    );
    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .reset_n(reset_n), .d(sda), .level(sda_l), .rise(sda_r), .fall(sda_f)
    );

    // A simultaneous sck edge masks START/STOP: sck must be high now and in the previous sample.
    assign start_c  = sda_f & sck_l & ~sck_r;
    assign stop_c   = sda_r & sck_l & ~sck_r;
    assign sda      = drive ? 1'b0 : 1'bz;
    assign bus.busy = state != S_IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            shift        <= '0;
            drive        <= 1'b0;
            ack_q        <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.rx_start <= 1'b0;
            bus.rx_stop  <= 1'b0;
        end else begin
            state        <= n_state;
            cnt          <= n_cnt;
            shift        <= n_shift;
            drive        <= n_drive;
            ack_q        <= n_ack_q;
            bus.rx_data  <= n_data;
            bus.rx_valid <= n_valid;
            bus.rx_start <= n_start;
            bus.rx_stop  <= n_stop;
        end
    end

    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_shift = shift;
        n_drive = drive;
        n_ack_q = ack_q;
        n_data  = bus.rx_data;
        n_valid = 1'b0;
        n_start = 1'b0;
        n_stop  = 1'b0;
        if (start_c) begin
            n_state = S_ADDR;
            n_cnt   = '0;
            n_drive = 1'b0;
            n_start = 1'b1;
        end else if (stop_c && state != S_IDLE) begin
            n_state = S_IDLE;
            n_drive = 1'b0;
            n_stop  = 1'b1;
        end else begin
            case (state)
                S_ADDR, S_DATA: begin
                    if (cnt == BITS) begin
                        n_cnt = '0;
                        if (state == S_ADDR) begin
                            n_state = (shift[7:1] == ADDR && !shift[0]) ? S_ADDR_ACK : S_IGNORE;
                        end else begin
                            n_data  = shift;
                            n_valid = 1'b1;
                            n_state = S_DATA_ACK;
                        end
                    end else if (sck_r) begin
                        n_shift = {shift[6:0], sda_l};
                        n_cnt   = cnt + 4'd1;
                        n_ack_q = (cnt == BITS - 4'd1) ? bus.ack_en : ack_q;
                    end
                end
                // cnt 0: waiting for the fall that opens the ACK slot; cnt 1: waiting for the one that closes it.
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (sck_f) begin
                        n_drive = (cnt == 4'd0) && (state == S_ADDR_ACK || ack_q);
                        n_cnt   = (cnt == 4'd0) ? 4'd1 : 4'd0;
                        n_state = (cnt == 4'd0) ? state : S_DATA;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- Bit/byte-level I2C target (slave) receiver; the far end of the bit-level I2C master transmitter.
- Synchronises SCK/SDA into the system clock and detects START/STOP.
- Shifts in the address byte, then data bytes, MSB first.
- Drives ACK on SDA (open-drain) and presents each received data byte with a one-cycle valid pulse. Write transfers only; read requests are NACKed.

Parameters:
- ADDR, 7'h42, 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2, synchroniser flops on SCK and SDA (minimum 2).

Ports:
- clk  input  1  system clock (50 MHz nominal); must be at least 10x the SCK rate.
- reset_n  input  1  asynchronous, active-low reset.
- sck  input  1  I2C clock from the master.
- sda  inout  1  I2C data. Driven 1'b0 only when acking, otherwise 1'bz.
- ack_en  input  1  1 = ACK data bytes, 0 = NACK data bytes. Address ACK is unaffected.
- rx_data  output  8  last complete data byte; holds until the next byte completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_start  output  1  one-cycle pulse on START or repeated START.
- rx_stop  output  1  one-cycle pulse on STOP.
- busy  output  1  high from START until STOP or reset.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; sda released (z); all outputs 0; rx_data=8'h00.
  - Synchronisers load 1 (bus idle).
- Synchronisation and edges:
  - Each pin is synchronised by SYNC_STAGES flops followed by one "previous" flop.
  - Edge event = current != previous. Pin-to-event latency is SYNC_STAGES+1 clk.
- START: synchronised sda falls while sck is high in both current and previous samples.
- STOP: synchronised sda rises while sck is high in both current and previous samples.
- If sck and sda change in the same sample, the change is treated as an sck edge only (no START/STOP).
- States:
  - IDLE: START -> ADDR, bit count=0, rx_start pulse, busy=1.
  - ADDR:
    - Shift sda into the shift register on each sck rising edge.
    - After the 8th rising edge:
      - shift[7:1]==ADDR and shift[0]==0 -> ADDR_ACK.
      - Otherwise -> IGNORE.
  - ADDR_ACK:
    - On the next sck falling edge, drive sda low.
    - Hold sda low through the 9th sck high period.
    - On the following sck falling edge, release sda -> DATA, count=0.
  - DATA:
    - Shift on sck rising edges.
    - After the 8th rising edge, on the next clk: rx_data=shift, rx_valid=1 for one clk -> DATA_ACK.
  - DATA_ACK:
    - Same timing as ADDR_ACK.
    - sda is driven low only if ack_en was 1 when the 8th bit was sampled; otherwise sda stays z (NACK).
    - Then -> DATA.
  - IGNORE:
    - sda never driven; no rx_valid.
    - Wait for START (-> ADDR) or STOP (-> IDLE).
- In every non-IDLE state:
  - STOP -> IDLE: release sda, rx_stop pulse, busy=0; discard any partial byte.
  - Repeated START -> ADDR: release sda, rx_start pulse, count=0; discard any partial byte.
- STOP or START detected while sda is driven low cannot occur on a legal bus; if it does, the same transitions apply.
- Bit counter is 4 bits wide, cleared on START and on every exit from an ACK state.
- No data backpressure: a consumer that misses rx_valid loses the byte.
- Reset mid-ACK releases sda asynchronously.

Decomposition:
- Shared header (i2c_target_rx.h) holds:
  - state encodings IDLE=0, ADDR=1, ADDR_ACK=2, DATA=3, DATA_ACK=4, IGNORE=5;
  - default address constant;
  - the bits-per-byte constant 8.
- One sub-module, i2c_sync_edge:
  - SYNC_STAGES synchroniser plus previous flop, with async active-low reset to 1.
  - Outputs: level, rise, fall.
  - Instantiated once for sck and once for sda.

Test Plan:
- Address match: START, byte 8'h84 (addr 0x42, W) -> sda=0 during the 9th sck high period, released after the 9th fall; rx_start one pulse; busy=1.
- Data byte: continue with byte 8'hA5, ack_en=1 -> rx_data=8'hA5, rx_valid exactly one clk, sda=0 in the ACK slot; then STOP -> rx_stop pulse, busy=0.
- Wrong address or read:
  - Byte 8'h86 -> sda never 0 and no rx_valid for a following byte 8'h3C; STOP returns to IDLE.
  - Byte 8'h85 (read) -> NACK.
- NACK data: ack_en=0, byte 8'h5A -> rx_data=8'h5A with rx_valid pulse, sda stays z in the ACK slot.
- Repeated START after 4 data bits: partial byte discarded, no rx_valid, second rx_start pulse; byte 8'h84 then 8'h0F -> rx_data=8'h0F.
- Reset mid-ACK: reset_n low while sda is driven -> sda=z immediately, all outputs 0; after release, the next START frame works normally.
